bsg_manycore_eva_to_npa_pipe: RTL and testbench
===============================================

# bsg_manycore_eva_to_npa_pipe

Pipelined, parametrised EVA-to-NPA translator for manycore endpoints that issue remote requests at one per cycle. It sits between an endpoint's request generator and its network link. It replaces fixed-function translation with three things: a valid/ready pipeline, `num_windows_p` runtime-programmable DMEM-overflow windows that remap tile-group addresses into DRAM space, and a saturating invalid-address counter. DRAM striping reuses the existing `bsg_manycore_dram_hash_function`.

## Interface

**Parameters**
- `data_width_p`, 32: EVA width. The block supports exactly 32.
- `addr_width_p`, 28: EPA word-address width.
- `x_cord_width_p`, 7: global x coordinate width.
- `y_cord_width_p`, 7: global y coordinate width.
- `pod_x_cord_width_p`, 3: pod x width.
- `pod_y_cord_width_p`, 4: pod y width.
- `num_tiles_x_p`, 16: tiles per pod in x; subcoordinate width is clog2 of this.
- `num_tiles_y_p`, 8: tiles per pod in y; subcoordinate width is clog2 of this.
- `num_vcache_rows_p`, 1: passed to the DRAM hash.
- `vcache_block_size_in_words_p`, 8: passed to the DRAM hash.
- `num_windows_p`, 2: overflow windows; range 1..8.
- `dmem_addr_width_p`, 10: local DMEM word-address bits kept for a plain tile-group EPA.
- `count_width_p`, 16: invalid-counter width.

**Ports**
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `v_i`  in  1  request valid.
- `ready_o`  out  1  request accepted when `v_i & ready_o`.
- `eva_i`  in  32  byte EVA.
- `tgo_x_i`, `tgo_y_i`  in  subcoordinate widths  tile-group origin; sampled at accept.
- `pod_x_i`, `pod_y_i`  in  pod widths  pod coordinates; quasi-static.
- `v_o`  out  1  result valid.
- `yumi_i`  in  1  consumer takes the result; legal only while `v_o` is high.
- `x_cord_o`, `y_cord_o`  out  coordinate widths  destination coordinates.
- `epa_o`  out  `addr_width_p`  endpoint physical word address.
- `is_invalid_addr_o`  out  1  EVA maps to no NPA.
- `window_hit_o`  out  1  result came from an overflow window.
- `cfg_v_i`  in  1  window register write strobe.
- `cfg_idx_i`  in  clog2(`num_windows_p`)  window selected for the write.
- `cfg_en_i`  in  1  window enable value.
- `cfg_base_i`, `cfg_limit_i`  in  16  inclusive tile-group word-address range.
- `cfg_remap_i`  in  31  DRAM byte base (EVA bits 30:0).
- `count_clear_i`  in  1  clears the invalid counter.
- `invalid_count_o`  out  `count_width_p`  saturating count of invalid results consumed.

## Operation

**Classify** (combinational on `eva_i`, evaluated at accept):
- DRAM: bit 31 set.
- Global: remote field = 2'b01.
- Tile-group: remote field = 3'b001.
- Anything else is invalid.

**Window match**
- Tile-group requests only.
- Window w hits when enabled, `base_w <= addr <= limit_w`, compared unsigned.
- The lowest-index hit wins.
- A window with base > limit never hits.
- Matching uses configuration registers as they stand in the accept cycle.

**Stage 1** (accept register) captures eva, tgo, class, hit flag and winning index.

**Stage 2** (output register) loads one of the following:
- DRAM: DRAM hash of eva.
- Global: coordinates and EPA taken directly from the EVA fields; EPA zero-extended.
- Window hit: remapped EVA = {1, (remap_w + ((addr − base_w) << 2) + eva[1:0]) mod 2^31}, then the DRAM hash. Sets `window_hit_o`.
- Tile-group, no hit:
  - x = {pod_x, (tg_x + tgo_x) mod 2^subw}; y is formed the same way.
  - EPA = addr[`dmem_addr_width_p`−1:0], zero-extended.
- Invalid: coordinates and EPA = 0; `is_invalid_addr_o` = 1.

**Config writes**
- Registered and visible from the next cycle.
- A write in the same cycle as an accept does not affect that request.

**Invalid counter**
- Increments on `v_o & yumi_i & is_invalid_addr_o`.
- Saturates at all-ones.
- Clear has priority over increment.

## Timing

**Latency and throughput**
- Accept at edge N gives `v_o` = 1 after edge N+1: two-cycle latency.
- Sustained throughput is one request per cycle.

**Stall rules**
- Stage 2 advances when `!v_o | yumi_i`.
- `ready_o` = `!s1_v | stage-2 advance`. It is combinational and does not depend on `v_i`.
- While `v_o & !yumi_i`, every output holds stable.

**Reset**
- Reset is asynchronous; deassertion must be synchronous to `clk_i`.
- Reset clears: `s1_v`, `v_o`, all outputs, window enables/base/limit/remap, and the counter.
- While reset is asserted, `v_i`, `cfg_v_i` and `count_clear_i` are ignored.
- Reset mid-flight drops in-flight requests; no result is produced for them.
- First cycle after reset: `ready_o` = 1.

## Test plan

- **Global EVA** (x_cord = 3, y_cord = 2, word addr 0x10) with `yumi_i` held high -> `v_o` two cycles later; x = 3, y = 2, epa = 0x10, invalid = 0.
- **Tile-group, no window:** tg_x = 5, tgo_x = 14, pod_x = 1, addr 0x0845 -> x = {1, 4'h3} (wrap), epa = 0x045, `window_hit_o` = 0.
- **Window 0 hit:** window 0 = {en, base 0x0040, limit 0xFC3F, remap 0x0010_0000}; tile-group addr 0x0041 -> result equals the DRAM hash of EVA 0x8010_0004, `window_hit_o` = 1.
  - Also enable window 1 over the same range: window 0 still wins.
  - Write window 0 in the accept cycle: the old value is used.
- **Back-pressure:** 4 back-to-back requests with `yumi_i` low for 3 cycles -> `ready_o` drops after 2 accepts; outputs stable; all 4 delivered in order with none lost or duplicated.
- **Invalid counter:** EVA 0x0000_0000 -> invalid = 1 and coordinates/EPA = 0.
  - Consume 3 such results -> count = 3.
  - `count_clear_i` together with a consuming invalid -> count = 0.
  - Counter preloaded to all-ones holds.
- **Reset mid-operation:** assert `reset_n_i` low with both stages full -> `v_o` = 0 immediately, `ready_o` = 1 after release, windows disabled.

Source files
------------

// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// bsg_manycore_eva_to_npa_pipe: two-stage EVA->NPA translator with
// programmable DMEM-overflow windows and a saturating invalid counter.
module bsg_manycore_eva_to_npa_pipe
    #(parameter int data_width_p                 = 32
    , parameter int addr_width_p                 = 28
    , parameter int x_cord_width_p               = 7
    , parameter int y_cord_width_p               = 7
    , parameter int pod_x_cord_width_p           = 3
    , parameter int pod_y_cord_width_p           = 4
    , parameter int num_tiles_x_p                = 16
    , parameter int num_tiles_y_p                = 8
    , parameter int num_vcache_rows_p            = 1
    , parameter int vcache_block_size_in_words_p = 8
    , parameter int num_windows_p                = 2
    , parameter int dmem_addr_width_p            = 10
    , parameter int count_width_p                = 16
    )
    (input  logic                                    clk_i
    , input  logic                                   reset_n_i
    , input  logic                                   v_i
    , output logic                                   ready_o
    , input  logic [data_width_p-1:0]                eva_i
    , input  logic [$clog2(num_tiles_x_p)-1:0]       tgo_x_i
    , input  logic [$clog2(num_tiles_y_p)-1:0]       tgo_y_i
    , input  logic [pod_x_cord_width_p-1:0]          pod_x_i
    , input  logic [pod_y_cord_width_p-1:0]          pod_y_i
    , output logic                                   v_o
    , input  logic                                   yumi_i
    , output logic [x_cord_width_p-1:0]              x_cord_o
    , output logic [y_cord_width_p-1:0]              y_cord_o
    , output logic [addr_width_p-1:0]                epa_o
    , output logic                                   is_invalid_addr_o
    , output logic                                   window_hit_o
    , input  logic                                   cfg_v_i
    , input  logic [((num_windows_p > 1) ? $clog2(num_windows_p) : 1)-1:0] cfg_idx_i
    , input  logic                                   cfg_en_i
    , input  logic [15:0]                            cfg_base_i
    , input  logic [15:0]                            cfg_limit_i
    , input  logic [30:0]                            cfg_remap_i
    , input  logic                                   count_clear_i
    , output logic [count_width_p-1:0]               invalid_count_o
    );

    localparam int sx_w  = $clog2(num_tiles_x_p);
    localparam int sy_w  = $clog2(num_tiles_y_p);
    localparam int idx_w = (num_windows_p > 1) ? $clog2(num_windows_p) : 1;
    localparam int lg_bs = $clog2(vcache_block_size_in_words_p);
    localparam int lg_r  = $clog2(num_vcache_rows_p);

    typedef enum logic [1:0] {CL_INV, CL_DRAM, CL_GLB, CL_TG} cls_e;

    typedef struct packed {
        logic [x_cord_width_p-1:0] x;
        logic [y_cord_width_p-1:0] y;
        logic [addr_width_p-1:0]   epa;
    } hash_t;

    // Word address: block offset, then vcache column, then north/south, then row/index.
    function automatic hash_t dram_hash(input logic [31:0] e,
                                        input logic [pod_x_cord_width_p-1:0] px,
                                        input logic [pod_y_cord_width_p-1:0] py);
        hash_t r;
        logic [28:0] word;
        logic [28:0] rest;
        logic [sy_w-1:0] row;
        word = 29'((e & 32'h7fff_ffff) >> 2);
        rest = word >> (lg_bs + sx_w + 1);
        row  = sy_w'(rest & 29'(num_vcache_rows_p - 1));
        r.x  = {px, word[lg_bs +: sx_w]};
        r.epa = addr_width_p'(((rest >> lg_r) << lg_bs)
                              | (word & 29'((1 << lg_bs) - 1)));
        if (word[lg_bs + sx_w])
            r.y = {py + pod_y_cord_width_p'(1), row};
        else
            r.y = {py - pod_y_cord_width_p'(1), {sy_w{1'b1}} - row};
        return r;
    endfunction

    logic        win_en    [num_windows_p];
    logic [15:0] win_base  [num_windows_p];
    logic [15:0] win_limit [num_windows_p];
    logic [30:0] win_remap [num_windows_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int w = 0; w < num_windows_p; w++) begin
                win_en[w]    <= 1'b0;
                win_base[w]  <= '0;
                win_limit[w] <= '0;
                win_remap[w] <= '0;
            end
        end else if (cfg_v_i && (32'(cfg_idx_i) < num_windows_p)) begin
            win_en[cfg_idx_i]    <= cfg_en_i;
            win_base[cfg_idx_i]  <= cfg_base_i;
            win_limit[cfg_idx_i] <= cfg_limit_i;
            win_remap[cfg_idx_i] <= cfg_remap_i;
        end
    end

    logic [15:0]      in_addr;
    cls_e             in_cls;
    logic             any_hit;
    logic [idx_w-1:0] sel;
    logic [15:0]      win_off;
    logic [30:0]      remap_sum;

    assign in_addr = eva_i[17:2];

    always_comb begin
        in_cls = CL_INV;
        unique case (1'b1)
            eva_i[31]:                  in_cls = CL_DRAM;
            (eva_i[31:30] == 2'b01):    in_cls = CL_GLB;
            (eva_i[31:29] == 3'b001):   in_cls = CL_TG;
            default:                    in_cls = CL_INV;
        endcase
    end

    // Scan downward so the lowest-index hit is the one left in sel.
    always_comb begin
        any_hit = 1'b0;
        sel     = '0;
        for (int w = num_windows_p - 1; w >= 0; w--) begin
            if (win_en[w] && (win_base[w] <= in_addr)
                && (in_addr <= win_limit[w])) begin
                any_hit = 1'b1;
                sel     = idx_w'(w);
            end
        end
    end

    assign win_off   = in_addr - win_base[sel];
    assign remap_sum = win_remap[sel] + 31'({win_off, 2'b00})
                     + 31'(eva_i[1:0]);

    logic             s1_v;
    logic [31:0]      s1_eva;
    logic [sx_w-1:0]  s1_tgo_x;
    logic [sy_w-1:0]  s1_tgo_y;
    cls_e             s1_cls;
    logic             s1_hit;
    logic             hit;
    logic             adv;

    assign hit     = any_hit & (in_cls == CL_TG);
    assign adv     = !v_o | yumi_i;
    assign ready_o = !s1_v | adv;

    // A window hit is rewritten into a DRAM EVA at accept time.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v     <= 1'b0;
            s1_eva   <= '0;
            s1_tgo_x <= '0;
            s1_tgo_y <= '0;
            s1_cls   <= CL_INV;
            s1_hit   <= 1'b0;
        end else if (ready_o) begin
            s1_v <= v_i;
            if (v_i) begin
                s1_eva   <= hit ? {1'b1, remap_sum} : eva_i;
                s1_tgo_x <= tgo_x_i;
                s1_tgo_y <= tgo_y_i;
                s1_cls   <= hit ? CL_DRAM : in_cls;
                s1_hit   <= hit;
            end
        end
    end

    hash_t                     h;
    logic [x_cord_width_p-1:0] nx_x;
    logic [y_cord_width_p-1:0] nx_y;
    logic [addr_width_p-1:0]   nx_epa;
    logic                      nx_inv;

    assign h = dram_hash(s1_eva, pod_x_i, pod_y_i);

    always_comb begin
        nx_x   = '0;
        nx_y   = '0;
        nx_epa = '0;
        nx_inv = 1'b0;
        unique case (s1_cls)
            CL_DRAM: begin
                nx_x   = h.x;
                nx_y   = h.y;
                nx_epa = h.epa;
            end
            CL_GLB: begin
                nx_x   = s1_eva[16 +: x_cord_width_p];
                nx_y   = s1_eva[16 + x_cord_width_p +: y_cord_width_p];
                nx_epa = addr_width_p'(s1_eva[15:2]);
            end
            CL_TG: begin
                nx_x   = {pod_x_i, s1_eva[18 +: sx_w] + s1_tgo_x};
                nx_y   = {pod_y_i, s1_eva[18 + sx_w +: sy_w] + s1_tgo_y};
                nx_epa = addr_width_p'(s1_eva[2 +: dmem_addr_width_p]);
            end
            default: nx_inv = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o               <= 1'b0;
            x_cord_o          <= '0;
            y_cord_o          <= '0;
            epa_o             <= '0;
            is_invalid_addr_o <= 1'b0;
            window_hit_o      <= 1'b0;
        end else if (adv) begin
            v_o <= s1_v;
            if (s1_v) begin
                x_cord_o          <= nx_x;
                y_cord_o          <= nx_y;
                epa_o             <= nx_epa;
                is_invalid_addr_o <= nx_inv;
                window_hit_o      <= s1_hit;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            invalid_count_o <= '0;
        else if (count_clear_i)
            invalid_count_o <= '0;
        else if (v_o && yumi_i && is_invalid_addr_o && !(&invalid_count_o))
            invalid_count_o <= invalid_count_o + count_width_p'(1);
    end

endmodule

// File: tb/tb_bsg_manycore_eva_to_npa_pipe.sv
// Bench for bsg_manycore_eva_to_npa_pipe: arithmetic reference model with a
// queue scoreboard, plus hand-computed directed expectations.
module tb_bsg_manycore_eva_to_npa_pipe;

    localparam int NTX = 16, NTY = 8, BS = 8, ROWS = 1, NW = 2, CW = 4;
    localparam int POD_X = 1, POD_Y = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, v_i, ready_o, v_o, yumi_i, yumi_en;
    logic [31:0] eva_i;
    logic [3:0]  tgo_x_i;
    logic [2:0]  tgo_y_i;
    logic [2:0]  pod_x_i;
    logic [3:0]  pod_y_i;
    logic [6:0]  x_o, y_o;
    logic [27:0] epa_o;
    logic        inv_o, hit_o;
    logic        cfg_v, cfg_idx, cfg_en, clr;
    logic [15:0] cfg_base, cfg_limit;
    logic [30:0] cfg_remap;
    logic [CW-1:0] cnt;

    assign yumi_i  = yumi_en & v_o;
    assign pod_x_i = 3'(POD_X);
    assign pod_y_i = 4'(POD_Y);

    bsg_manycore_eva_to_npa_pipe #(.num_windows_p(NW), .count_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o),
        .eva_i(eva_i), .tgo_x_i(tgo_x_i), .tgo_y_i(tgo_y_i),
        .pod_x_i(pod_x_i), .pod_y_i(pod_y_i), .v_o(v_o), .yumi_i(yumi_i),
        .x_cord_o(x_o), .y_cord_o(y_o), .epa_o(epa_o),
        .is_invalid_addr_o(inv_o), .window_hit_o(hit_o),
        .cfg_v_i(cfg_v), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
        .cfg_base_i(cfg_base), .cfg_limit_i(cfg_limit), .cfg_remap_i(cfg_remap),
        .count_clear_i(clr), .invalid_count_o(cnt));

    typedef struct packed {
        logic [6:0] x; logic [6:0] y; logic [27:0] epa; logic inv; logic hit;
    } exp_t;

    int n_cmp = 0, n_bad = 0, n_cons = 0;
    exp_t q[$];
    bit          sh_en [NW];
    logic [15:0] sh_base [NW], sh_lim [NW];
    logic [30:0] sh_rm [NW];
    int          mcount = 0;
    logic [6:0]  lx, ly;
    logic [27:0] lepa;
    logic        linv, lhit;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t dram_m(input logic [31:0] e);
        exp_t r;
        int unsigned word, rest, row, south;
        word  = (e & 32'h7fff_ffff) >> 2;
        south = (word / (BS * NTX)) % 2;
        rest  = word / (BS * NTX * 2);
        row   = rest % ROWS;
        r     = '0;
        r.epa = 28'((rest / ROWS) * BS + word % BS);
        r.x   = 7'(POD_X * NTX + (word / BS) % NTX);
        r.y   = (south != 0) ? 7'(((POD_Y + 1) % 16) * NTY + row)
                             : 7'(((POD_Y + 15) % 16) * NTY + (NTY - 1 - row));
        return r;
    endfunction

    function automatic exp_t model(input logic [31:0] e, input int tx, input int ty);
        exp_t r;
        int unsigned a;
        int hw;
        longint unsigned m;
        r = '0;
        if (e[31]) r = dram_m(e);
        else if (e[31:30] == 2'b01) begin
            r.x = e[22:16]; r.y = e[29:23]; r.epa = 28'(e[15:2]);
        end else if (e[31:29] == 3'b001) begin
            a  = (e >> 2) & 32'hffff;
            hw = -1;
            for (int w = 0; w < NW; w++)
                if (hw < 0 && sh_en[w] && sh_base[w] <= a && a <= sh_lim[w]) hw = w;
            if (hw >= 0) begin
                m = (longint'(sh_rm[hw]) + longint'(a - sh_base[hw]) * 4
                     + longint'(e % 4)) % 64'h8000_0000;
                r = dram_m(32'h8000_0000 | 32'(m));
                r.hit = 1'b1;
            end else begin
                r.x   = 7'(POD_X * NTX + (((e >> 18) % 16) + tx) % 16);
                r.y   = 7'(POD_Y * NTY + (((e >> 22) % 8) + ty) % 8);
                r.epa = 28'(a % 1024);
            end
        end else r.inv = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit cons, einv;
        if (!reset_n) begin
            q.delete();
            mcount = 0;
            for (int w = 0; w < NW; w++) begin
                sh_en[w] = 0; sh_base[w] = 0; sh_lim[w] = 0; sh_rm[w] = 0;
            end
        end else begin
            chk("count", cnt, mcount);
            cons = v_o && yumi_i;
            einv = inv_o;
            if (cons) begin
                if (q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    e = q.pop_front();
                    einv = e.inv;
                    chk("x", x_o, e.x);
                    chk("y", y_o, e.y);
                    chk("epa", epa_o, e.epa);
                    chk("inv", inv_o, e.inv);
                    chk("hit", hit_o, e.hit);
                end
                lx = x_o; ly = y_o; lepa = epa_o; linv = inv_o; lhit = hit_o;
                n_cons++;
            end
            if (v_i && ready_o) q.push_back(model(eva_i, int'(tgo_x_i), int'(tgo_y_i)));
            if (clr) mcount = 0;
            else if (cons && einv && mcount != (1 << CW) - 1) mcount++;
            if (cfg_v) begin
                sh_en[cfg_idx] = cfg_en; sh_base[cfg_idx] = cfg_base;
                sh_lim[cfg_idx] = cfg_limit; sh_rm[cfg_idx] = cfg_remap;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] e, input logic [3:0] tx, input logic [2:0] ty);
        int n = 0;
        v_i = 1'b1; eva_i = e; tgo_x_i = tx; tgo_y_i = ty;
        @(negedge clk);
        while (!ready_o && n < 50) begin n++; @(negedge clk); end
        if (!ready_o) chk("send_timeout", ready_o, 1);
        tick();
        v_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || v_o) && n < 200) begin tick(); n++; end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic cfg(input int idx, input logic en, input logic [15:0] b,
                       input logic [15:0] l, input logic [30:0] rm);
        cfg_v = 1'b1; cfg_idx = 1'(idx); cfg_en = en;
        cfg_base = b; cfg_limit = l; cfg_remap = rm;
        tick();
        cfg_v = 1'b0;
    endtask

    task automatic pin(input string nm, input int x, input int y, input int epa,
                       input int inv, input int hit);
        chk({nm, "_x"}, lx, x);
        chk({nm, "_y"}, ly, y);
        chk({nm, "_epa"}, lepa, epa);
        chk({nm, "_inv"}, linv, inv);
        chk({nm, "_hit"}, lhit, hit);
    endtask

    initial begin
        int c0, n;
        logic [6:0] sx;
        logic [27:0] sepa;
        reset_n = 0; v_i = 0; eva_i = 0; tgo_x_i = 0; tgo_y_i = 0; yumi_en = 0;
        cfg_v = 0; cfg_idx = 0; cfg_en = 0; cfg_base = 0; cfg_limit = 0;
        cfg_remap = 0; clr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_v_o", v_o, 0);
        chk("rst_count", cnt, 0);
        @(posedge clk); #1 reset_n = 1;
        @(negedge clk);
        chk("rst_ready", ready_o, 1);
        tick();
        yumi_en = 1;

        send(32'h4103_0040, 0, 0);
        chk("lat_edge1_v_o", v_o, 0);
        tick();
        chk("lat_edge2_v_o", v_o, 1);
        drain();
        pin("global", 3, 2, 'h10, 0, 0);

        send(32'h2014_2114, 4'd14, 3'd0);
        drain();
        pin("tg_wrap", 'h13, 'h10, 'h45, 0, 0);
        send(32'h2180_048c, 4'd0, 3'd3);
        send(32'h8123_4567, 4'd0, 3'd0);
        send(32'h8000_0380, 4'd0, 3'd0);
        drain();
        pin("dram", 28, 24, 0, 0, 0);

        cfg(0, 1, 16'h0040, 16'hfc3f, 31'h0010_0000);
        send(32'h2000_0104, 0, 0);
        drain();
        pin("win0", 16, 15, 'h2001, 0, 1);
        cfg(1, 1, 16'h0040, 16'hfc3f, 31'h0030_0000);
        send(32'h2000_0104, 0, 0);
        drain();
        pin("win0_prio", 16, 15, 'h2001, 0, 1);
        send(32'h2003_f0fc, 0, 0);
        send(32'h2003_f100, 0, 0);
        send(32'h2000_00fc, 0, 0);
        drain();
        chk("win_below_base_hit", lhit, 0);

        cfg_v = 1; cfg_idx = 0; cfg_en = 1; cfg_base = 16'h0040;
        cfg_limit = 16'hfc3f; cfg_remap = 31'h0020_0000;
        send(32'h2000_0104, 0, 0);
        cfg_v = 0;
        drain();
        pin("win_same_cycle", 16, 15, 'h2001, 0, 1);
        send(32'h2000_0104, 0, 0);
        drain();
        pin("win_new_remap", 16, 15, 'h4001, 0, 1);

        cfg(0, 0, 16'h0040, 16'hfc3f, 31'h0020_0000);
        cfg(1, 1, 16'h0100, 16'h0050, 31'h0);
        send(32'h2000_0200, 0, 0);
        drain();
        chk("base_gt_limit_hit", lhit, 0);

        yumi_en = 0;
        c0 = n_cons;
        send(32'h4103_0004, 0, 0);
        send(32'h4103_0008, 0, 0);
        chk("bp_ready", ready_o, 0);
        chk("bp_v_o", v_o, 1);
        sx = x_o; sepa = epa_o;
        repeat (3) begin
            tick();
            chk("bp_hold_epa", epa_o, sepa);
            chk("bp_hold_x", x_o, sx);
            chk("bp_hold_ready", ready_o, 0);
        end
        yumi_en = 1;
        send(32'h4103_000c, 0, 0);
        send(32'h4103_0010, 0, 0);
        drain();
        chk("bp_delivered", n_cons - c0, 4);
        chk("bp_last_epa", lepa, 4);

        repeat (3) send(32'h0, 0, 0);
        drain();
        @(negedge clk);
        chk("cnt_three", cnt, 3);
        pin("invalid", 0, 0, 0, 1, 0);
        tick();
        yumi_en = 0;
        send(32'h0, 0, 0);
        n = 0;
        while (!v_o && n < 10) begin tick(); n++; end
        chk("clr_wait_v_o", v_o, 1);
        clr = 1; yumi_en = 1;
        tick();
        clr = 0;
        chk("cnt_cleared", cnt, 0);
        repeat (20) send(32'h0, 0, 0);
        drain();
        chk("cnt_saturated", cnt, 15);
        send(32'h0, 0, 0);
        drain();
        chk("cnt_sat_hold", cnt, 15);

        cfg(0, 1, 16'h0040, 16'hfc3f, 31'h0010_0000);
        yumi_en = 0;
        send(32'h4103_0014, 0, 0);
        send(32'h4103_0018, 0, 0);
        chk("mid_full_v_o", v_o, 1);
        reset_n = 0;
        #1 chk("mid_rst_v_o", v_o, 0);
        tick(); tick();
        reset_n = 1;
        @(negedge clk);
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_cnt", cnt, 0);
        tick();
        yumi_en = 1;
        c0 = n_cons;
        send(32'h2000_0104, 0, 0);
        drain();
        chk("mid_rst_delivered", n_cons - c0, 1);
        pin("mid_rst_win_off", 16, 16, 'h41, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
